// File: rtl/spike_window_counter.sv
// Counts output-layer spikes per neuron over a programmable window of cycles,
// then publishes saturated per-neuron counts and the index of the winning neuron.
//
// Handshake: start is a level request sampled only in IDLE; the edge that sees
// start=1 in IDLE accepts it and captures window_len. done is a one-cycle pulse
// in the cycle after results load, and start may be raised in that same cycle.
// abort is sampled in RUN/DONE and wins over both start and window completion.
module spike_window_counter #(
    parameter int NUM_OUTPUTS  = 1,
    parameter int COUNT_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 32,
    localparam int WINNER_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [NUM_OUTPUTS-1:0]             spike_in,
    input  logic                               start,
    input  logic                               abort,
    input  logic [WINDOW_WIDTH-1:0]            window_len,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] counts,
    output logic [WINNER_WIDTH-1:0]            winner,
    output logic                               winner_valid,
    output logic [1:0]                         state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ACC_MAX = '1;

    state_t                  state;
    logic [WINDOW_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0]  acc [NUM_OUTPUTS];

    logic [COUNT_WIDTH-1:0]  best_cnt;
    logic [WINNER_WIDTH-1:0] best_idx;
    logic                    any_nonzero;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Strict greater-than keeps the lowest index among tied maxima.
    always_comb begin
        best_cnt    = acc[0];
        best_idx    = '0;
        any_nonzero = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (acc[i] != '0) begin
                any_nonzero = 1'b1;
            end
            if (acc[i] > best_cnt) begin
                best_cnt = acc[i];
                best_idx = WINNER_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state        <= IDLE;
            remaining    <= '0;
            done         <= 1'b0;
            counts       <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            acc[i] <= '0;
                        end
                        remaining <= window_len;
                        state     <= (window_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            if (spike_in[i] && (acc[i] != ACC_MAX)) begin
                                acc[i] <= acc[i] + COUNT_WIDTH'(1);
                            end
                        end
                        remaining <= remaining - WINDOW_WIDTH'(1);
                        if (remaining == WINDOW_WIDTH'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!abort) begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            counts[i*COUNT_WIDTH +: COUNT_WIDTH] <= acc[i];
                        end
                        winner       <= best_idx;
                        winner_valid <= any_nonzero;
                        done         <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench for spike_window_counter: a table of held-spike windows plus
// hand-written sequences for abort, reset, saturation and back-to-back starts.
module tb_spike_window_counter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  spike_in;
  logic        start;
  logic        abort;
  logic [31:0] window_len;

  logic        busy, done, winner_valid;
  logic [63:0] counts;
  logic [1:0]  winner, state_dbg;

  logic        s_busy, s_done, s_winner_valid;
  logic [15:0] s_counts;
  logic [1:0]  s_winner, s_state_dbg;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] len;
    logic [3:0]  spk;
    logic [63:0] exp_counts;
    logic [1:0]  exp_win;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[5];

  spike_window_counter #(.NUM_OUTPUTS(4), .COUNT_WIDTH(16), .WINDOW_WIDTH(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .spike_in(spike_in), .start(start),
    .abort(abort), .window_len(window_len), .busy(busy), .done(done),
    .counts(counts), .winner(winner), .winner_valid(winner_valid), .state_dbg(state_dbg)
  );

  spike_window_counter #(.NUM_OUTPUTS(4), .COUNT_WIDTH(4), .WINDOW_WIDTH(32)) dut_sat (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .spike_in(spike_in), .start(start),
    .abort(abort), .window_len(window_len), .busy(s_busy), .done(s_done),
    .counts(s_counts), .winner(s_winner), .winner_valid(s_winner_valid),
    .state_dbg(s_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Open a window with spikes held, then check done timing and results.
  task automatic run_window(input string name, input logic [31:0] len, input logic [3:0] spk,
                            input logic [63:0] exp_counts, input logic [1:0] exp_win,
                            input logic exp_valid);
    logic early;
    @(negedge clk);
    start = 1'b1;
    window_len = len;
    spike_in = spk;
    @(posedge clk); #1;
    check({name, " busy_after_accept"}, busy, 1);
    @(negedge clk);
    start = 1'b0;
    window_len = 32'($urandom_range(1, 50));
    early = 1'b0;
    for (int k = 1; k <= int'(len); k++) begin
      @(posedge clk); #1;
      if (done) early = 1'b1;
    end
    check({name, " no_early_done"}, early, 0);
    @(posedge clk); #1;
    check({name, " done"}, done, 1);
    check({name, " busy_at_done"}, busy, 0);
    check({name, " counts"}, counts, exp_counts);
    check({name, " winner"}, winner, exp_win);
    check({name, " winner_valid"}, winner_valid, exp_valid);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    logic        seen_done;
    logic [11:0] pat;

    vecs[0] = '{32'd10, 4'b0101, {16'd0, 16'd10, 16'd0, 16'd10}, 2'd0, 1'b1};
    vecs[1] = '{32'd0,  4'b1111, 64'd0,                          2'd0, 1'b0};
    vecs[2] = '{32'd3,  4'b1000, {16'd3, 16'd0, 16'd0, 16'd0},   2'd3, 1'b1};
    vecs[3] = '{32'd5,  4'b0110, {16'd0, 16'd5, 16'd5, 16'd0},   2'd1, 1'b1};
    vecs[4] = '{32'd1,  4'b0100, {16'd0, 16'd1, 16'd0, 16'd0},   2'd2, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    spike_in = 4'b0;
    window_len = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset counts", counts, 0);
    check("reset winner_valid", winner_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_window($sformatf("vec%0d", v), vecs[v].len, vecs[v].spk,
                 vecs[v].exp_counts, vecs[v].exp_win, vecs[v].exp_valid);
    end

    // Results hold while spikes keep arriving in IDLE.
    @(negedge clk);
    spike_in = 4'b1111;
    repeat (5) @(posedge clk);
    #1;
    check("hold counts", counts, {16'd0, 16'd1, 16'd0, 16'd0});

    // Saturation on the 4-bit instance; the 16-bit one counts the full window.
    run_window("sat", 32'd20, 4'b0100, {16'd0, 16'd20, 16'd0, 16'd0}, 2'd2, 1'b1);
    check("sat count", s_counts, 16'h0F00);
    check("sat winner", s_winner, 2);

    // Abort in the 4th RUN cycle.
    @(negedge clk);
    start = 1'b1;
    window_len = 32'd8;
    spike_in = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort busy", busy, 0);
    @(negedge clk);
    abort = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort no_done", seen_done, 0);
    check("abort counts", counts, {16'd0, 16'd20, 16'd0, 16'd0});
    check("abort winner", winner, 2);

    // Abort during DONE suppresses the result update.
    @(negedge clk);
    start = 1'b1;
    window_len = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_done done", done, 0);
    check("abort_done busy", busy, 0);
    check("abort_done counts", counts, {16'd0, 16'd20, 16'd0, 16'd0});
    check("abort_done winner_valid", winner_valid, 1);

    // Abort in IDLE does not block start; held abort then closes the window.
    @(negedge clk);
    start = 1'b1;
    window_len = 32'd5;
    @(posedge clk); #1;
    check("idle_abort accepted", busy, 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_abort closes", busy, 0);
    @(negedge clk);
    abort = 1'b0;

    // Reset asserted mid-window clears everything at once.
    @(negedge clk);
    start = 1'b1;
    window_len = 32'd8;
    spike_in = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset counts", counts, 0);
    check("midreset winner", winner, 0);
    check("midreset winner_valid", winner_valid, 0);
    check("midreset state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_window("post_reset", 32'd3, 4'b1000, {16'd3, 16'd0, 16'd0, 16'd0}, 2'd3, 1'b1);

    // Start held high: back-to-back windows of length 2, done every 4 cycles.
    @(negedge clk);
    start = 1'b1;
    window_len = 32'd2;
    spike_in = 4'b0001;
    @(posedge clk);
    pat = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      pat[k-1] = done;
    end
    check("b2b done pattern", pat, 12'h444);
    check("b2b counts", counts, {16'd0, 16'd0, 16'd0, 16'd2});
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_window_counter.md
SPIKE_WINDOW_COUNTER -- requirements
Module: spike_window_counter

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 1, number of output-layer spike lines counted.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of each per-neuron spike count.
REQ-003 SHALL have parameter WINDOW_WIDTH, default 32, width of the window-length operand.
REQ-004 SHALL have port S_AXI_ACLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port spike_in  input  NUM_OUTPUTS  output-layer spikes from the network, one bit per neuron, one spike per high cycle.
REQ-007 SHALL have port start  input  1  request to open a counting window; sampled in IDLE only.
REQ-008 SHALL have port abort  input  1  cancels an open window.
REQ-009 SHALL have port window_len  input  WINDOW_WIDTH  window length in cycles; captured when start is accepted.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when results update.
REQ-012 SHALL have port counts  output  NUM_OUTPUTS*COUNT_WIDTH  result counts, neuron i at bits [i*COUNT_WIDTH +: COUNT_WIDTH].
REQ-013 SHALL have port winner  output  max(1,clog2(NUM_OUTPUTS))  index of the neuron with highest count.
REQ-014 SHALL have port winner_valid  output  1  high when at least one result count is nonzero.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 with window_len=N>0 SHALL clear internal accumulators, load remaining=N, go to RUN on that edge.
REQ-017 IDLE: start=1 with window_len=0 SHALL clear accumulators and go directly to DONE (empty window).
REQ-018 RUN: each cycle SHALL add spike_in[i] to accumulator i and decrement remaining; exactly N RUN cycles occur, the Nth moving to DONE.
REQ-019 Accumulators SHALL saturate at 2^COUNT_WIDTH-1; no wrap-around.
REQ-020 DONE: lasts one cycle; spike_in ignored; on its ending edge counts, winner, winner_valid SHALL load from accumulators, done SHALL be set for the next cycle, state SHALL return to IDLE.
REQ-021 done SHALL be high exactly N+2 cycles after the edge that accepted start (2 cycles for N=0).
REQ-022 winner SHALL be the lowest index among neurons sharing the maximum count; with all counts zero winner=0 and winner_valid=0.
REQ-023 start in RUN or DONE SHALL be ignored; start in the cycle done is high SHALL be accepted.
REQ-024 abort in RUN or DONE SHALL return to IDLE on the next edge, no done pulse, result outputs unchanged; abort has priority over start and over the RUN->DONE transition; abort in IDLE has no effect.
REQ-025 Result outputs SHALL hold their values from one done until the next done, unaffected by spike_in.
REQ-026 window_len changes after acceptance SHALL not affect the open window.

Reset
REQ-027 S_AXI_ARESETN low SHALL immediately force state IDLE, busy=0, done=0, counts=0, winner=0, winner_valid=0, accumulators=0, remaining=0, including mid-window.
REQ-028 After deassertion, the first start SHALL be accepted on the first rising edge at which it is sampled.

Verification (NUM_OUTPUTS=4, COUNT_WIDTH=16)
REQ-029 start, window_len=10, spike_in=4'b0101 held -> done 12 cycles after start edge, counts={0,10,0,10} (neuron3..0), winner=0, winner_valid=1.
REQ-030 start, window_len=0 -> done after 2 cycles, counts all 0, winner_valid=0.
REQ-031 COUNT_WIDTH=4, window_len=20, spike_in[2]=1 held -> count2=15 (saturated), winner=2.
REQ-032 window_len=8, abort at 4th RUN cycle -> busy low next cycle, no done, counts equal previous result.
REQ-033 reset asserted mid-window then released, start window_len=3 spike_in=4'b1000 -> outputs zero during reset; then done after 5 cycles, count3=3, winner=3.
REQ-034 start held high continuously with window_len=2 -> back-to-back windows, done every 4 cycles, start pulses in RUN/DONE ignored.
